// File: rtl/fifo_wr_gearbox.sv
// fifo_wr_gearbox: serializes wide upstream words into LSB-first beats for an async FIFO write port
// Optional feature macro: FIFO_WR_GEARBOX_PAR_EN appends an XOR parity beat after each word.
// Ports:
//   wr_clk, wr_rst_n          write-domain clock, asynchronous active-low reset
//   s_valid, s_data, s_ready  upstream word stream (IN_WIDTH bits)
//   fifo_wr_en, fifo_wr_data  FIFO write strobe and DATA_WIDTH-bit beat
//   fifo_full, fifo_afull     registered FIFO full / almost-full flags
//   busy                      a word is being serialized
//   words_sent                count of fully written words, wraps
module fifo_wr_gearbox #(
   parameter int IN_WIDTH    = 16,
   parameter int DATA_WIDTH  = 4,
   parameter int WORD_ATOMIC = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  wr_clk,
   input  logic                  wr_rst_n,
   input  logic                  s_valid,
   input  logic [IN_WIDTH-1:0]   s_data,
   output logic                  s_ready,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   input  logic                  fifo_full,
   input  logic                  fifo_afull,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_sent
);
   localparam int RATIO = IN_WIDTH / DATA_WIDTH;
   localparam int BW    = $clog2(RATIO);
`ifdef FIFO_WR_GEARBOX_PAR_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
   state_t state, state_n;
   logic [IN_WIDTH-1:0] sh, sh_n;
   logic [BW-1:0] cnt, cnt_n;
   logic beat_go, last_beat, accept, cnt_last;
   assign cnt_last   = cnt == BW'(RATIO - 1);
   assign beat_go    = state != IDLE && !fifo_full;
   assign fifo_wr_en = beat_go;
   assign busy       = state != IDLE;
   assign s_ready    = (state == IDLE || (last_beat && beat_go)) && (WORD_ATOMIC == 0 || !fifo_afull);
   assign accept     = s_valid && s_ready;
`ifdef FIFO_WR_GEARBOX_PAR_EN
   logic [DATA_WIDTH-1:0] par, par_in;
   assign last_beat    = state == PAR;
   assign fifo_wr_data = state == SHIFT ? sh[DATA_WIDTH-1:0] : state == PAR ? par : '0;
   always_comb begin
      par_in = '0;
      for (int i = 0; i < RATIO; i++) par_in = par_in ^ s_data[i*DATA_WIDTH +: DATA_WIDTH];
   end
   always_ff @(posedge wr_clk or negedge wr_rst_n)
      if (!wr_rst_n) par <= '0;
      else if (accept) par <= par_in;
`else
   assign last_beat    = state == SHIFT && cnt_last;
   assign fifo_wr_data = state == SHIFT ? sh[DATA_WIDTH-1:0] : '0;
`endif
   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      if (accept) begin
         state_n = SHIFT;
         sh_n    = s_data;
         cnt_n   = '0;
      end else if (beat_go) begin
         if (state == SHIFT && !cnt_last) begin
            sh_n  = sh >> DATA_WIDTH;
            cnt_n = cnt + BW'(1);
         end else begin
`ifdef FIFO_WR_GEARBOX_PAR_EN
            state_n = state == SHIFT ? PAR : IDLE;
`else
            state_n = IDLE;
`endif
         end
      end
   end
   always_ff @(posedge wr_clk or negedge wr_rst_n)
      if (!wr_rst_n) begin
         state      <= IDLE;
         sh         <= '0;
         cnt        <= '0;
         words_sent <= '0;
      end else begin
         state      <= state_n;
         sh         <= sh_n;
         cnt        <= cnt_n;
         words_sent <= last_beat && beat_go ? words_sent + CNT_WIDTH'(1) : words_sent;
      end
endmodule

// File: tb/tb_fifo_wr_gearbox.sv
// tb_fifo_wr_gearbox: directed self-checking bench for fifo_wr_gearbox
module tb_fifo_wr_gearbox;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_valid = 1'b0, s_valid_b = 1'b0;
   logic [15:0] s_data = '0;
   logic fifo_full = 1'b0, fifo_afull = 1'b0;
   logic s_ready, wr_en, busy;
   logic [3:0] wr_data;
   logic [15:0] words_sent;
   logic s_ready_b, wr_en_b, busy_b;
   logic [3:0] wr_data_b;
   logic [15:0] words_sent_b;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   fifo_wr_gearbox #(.IN_WIDTH(16), .DATA_WIDTH(4), .WORD_ATOMIC(0), .CNT_WIDTH(16)) dut (
      .wr_clk(clk), .wr_rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
      .busy(busy), .words_sent(words_sent));
   fifo_wr_gearbox #(.IN_WIDTH(16), .DATA_WIDTH(4), .WORD_ATOMIC(1), .CNT_WIDTH(16)) dut_b (
      .wr_clk(clk), .wr_rst_n(rst_n), .s_valid(s_valid_b), .s_data(s_data), .s_ready(s_ready_b),
      .fifo_wr_en(wr_en_b), .fifo_wr_data(wr_data_b), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
      .busy(busy_b), .words_sent(words_sent_b));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic beat(input string tag, input logic [3:0] d);
      chk({tag, "_en"}, 32'(wr_en), 32'd1);
      chk({tag, "_data"}, 32'(wr_data), 32'(d));
   endtask
   task automatic nxt;
      @(negedge clk);
      #1;
   endtask
   initial begin
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_words", 32'(words_sent), 32'd0);
      nxt;
      nxt;
      rst_n = 1'b1;
`ifndef FIFO_WR_GEARBOX_PAR_EN
      // single word, no throttling
      s_valid = 1'b1; s_data = 16'hA5C3; #1;
      chk("t1_ready", 32'(s_ready), 32'd1);
      chk("t1_busy0", 32'(busy), 32'd0);
      nxt; s_valid = 1'b0; s_data = 16'h0000; #1;
      beat("t1_b0", 4'h3); chk("t1_busy1", 32'(busy), 32'd1);
      nxt; beat("t1_b1", 4'hC);
      nxt; beat("t1_b2", 4'h5);
      nxt; beat("t1_b3", 4'hA); chk("t1_busy4", 32'(busy), 32'd1);
      nxt;
      chk("t1_idle_en", 32'(wr_en), 32'd0);
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_words", 32'(words_sent), 32'd1);
      // full held for three cycles from the second beat
      s_valid = 1'b1; s_data = 16'hA5C3; #1;
      nxt; s_valid = 1'b0; #1;
      beat("t2_b0", 4'h3); chk("t2_ready_b0", 32'(s_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         nxt; fifo_full = 1'b1; #1;
         chk("t2_hold_en", 32'(wr_en), 32'd0);
         chk("t2_hold_data", 32'(wr_data), 32'hC);
         chk("t2_hold_ready", 32'(s_ready), 32'd0);
      end
      nxt; fifo_full = 1'b0; #1;
      beat("t2_b1", 4'hC); chk("t2_ready_b1", 32'(s_ready), 32'd0);
      nxt; beat("t2_b2", 4'h5);
      nxt; beat("t2_b3", 4'hA);
      nxt; chk("t2_words", 32'(words_sent), 32'd2);
      // back-to-back words
      s_valid = 1'b1; s_data = 16'h1234; #1;
      chk("t3_ready_n", 32'(s_ready), 32'd1);
      nxt; s_data = 16'hABCD; #1;
      beat("t3_b0", 4'h4); chk("t3_ready_n1", 32'(s_ready), 32'd0);
      nxt; beat("t3_b1", 4'h3); chk("t3_ready_n2", 32'(s_ready), 32'd0);
      nxt; beat("t3_b2", 4'h2); chk("t3_ready_n3", 32'(s_ready), 32'd0);
      nxt; beat("t3_b3", 4'h1); chk("t3_ready_n4", 32'(s_ready), 32'd1);
      nxt; s_valid = 1'b0; s_data = 16'h0000; #1;
      beat("t3_b4", 4'hD); chk("t3_ready_n5", 32'(s_ready), 32'd0);
      chk("t3_words_mid", 32'(words_sent), 32'd3);
      nxt; beat("t3_b5", 4'hC);
      nxt; beat("t3_b6", 4'hB);
      nxt; beat("t3_b7", 4'hA);
      nxt;
      chk("t3_words", 32'(words_sent), 32'd4);
      chk("t3_idle_en", 32'(wr_en), 32'd0);
      // reset in the middle of a word
      s_valid = 1'b1; s_data = 16'hA5C3; #1;
      nxt; s_valid = 1'b0; #1;
      beat("t4_b0", 4'h3);
      nxt; beat("t4_b1", 4'hC);
      rst_n = 1'b0; #1;
      chk("t4_rst_en", 32'(wr_en), 32'd0);
      chk("t4_rst_data", 32'(wr_data), 32'd0);
      chk("t4_rst_busy", 32'(busy), 32'd0);
      chk("t4_rst_ready", 32'(s_ready), 32'd1);
      chk("t4_rst_words", 32'(words_sent), 32'd0);
      nxt; chk("t4_rst_en2", 32'(wr_en), 32'd0);
      rst_n = 1'b1;
      s_valid = 1'b1; s_data = 16'h0F0F; #1;
      nxt; s_valid = 1'b0; s_data = 16'h0000; #1;
      beat("t4_n0", 4'hF);
      nxt; beat("t4_n1", 4'h0);
      nxt; beat("t4_n2", 4'hF);
      nxt; beat("t4_n3", 4'h0);
      nxt;
      chk("t4_words", 32'(words_sent), 32'd1);
      chk("t4_idle_en", 32'(wr_en), 32'd0);
`else
      // parity beat after each word, next word taken on the parity beat
      s_valid = 1'b1; s_data = 16'h1234; #1;
      chk("p_ready_n", 32'(s_ready), 32'd1);
      nxt; s_data = 16'hABCD; #1;
      beat("p_b0", 4'h4); chk("p_ready_n1", 32'(s_ready), 32'd0);
      nxt; beat("p_b1", 4'h3);
      nxt; beat("p_b2", 4'h2);
      nxt; beat("p_b3", 4'h1); chk("p_ready_n4", 32'(s_ready), 32'd0);
      nxt; beat("p_par0", 4'h4); chk("p_ready_n5", 32'(s_ready), 32'd1);
      chk("p_words0", 32'(words_sent), 32'd0);
      nxt; s_valid = 1'b0; s_data = 16'h0000; #1;
      beat("p_b4", 4'hD); chk("p_words1", 32'(words_sent), 32'd1);
      nxt; beat("p_b5", 4'hC);
      nxt; beat("p_b6", 4'hB);
      nxt; beat("p_b7", 4'hA);
      nxt; beat("p_par1", 4'h0);
      nxt;
      chk("p_words2", 32'(words_sent), 32'd2);
      chk("p_idle_en", 32'(wr_en), 32'd0);
      chk("p_idle_busy", 32'(busy), 32'd0);
`endif
      // word-atomic instance throttled by afull in IDLE
      fifo_afull = 1'b1; s_valid_b = 1'b1; s_data = 16'h5678; #1;
      chk("t5_ready0", 32'(s_ready_b), 32'd0);
      chk("t5_en0", 32'(wr_en_b), 32'd0);
      nxt;
      chk("t5_en1", 32'(wr_en_b), 32'd0);
      chk("t5_busy1", 32'(busy_b), 32'd0);
      fifo_afull = 1'b0; #1;
      chk("t5_ready1", 32'(s_ready_b), 32'd1);
      nxt; s_valid_b = 1'b0; #1;
      chk("t5_busy2", 32'(busy_b), 32'd1);
      chk("t5_en2", 32'(wr_en_b), 32'd1);
      chk("t5_data2", 32'(wr_data_b), 32'h8);
      repeat (6) nxt;
      chk("t5_words", 32'(words_sent_b), 32'd1);
      chk("t5_idle", 32'(busy_b), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
